// File: rtl/sh7604_pkg.sv
// rtl/sh7604_pkg.sv - shared types and match helpers for the SH7604 user break controller
package sh7604_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEQ_A = 2'd1,
        ST_PEND  = 2'd2
    } ubc_state_e;

    typedef struct packed {
        logic [7:0] rsv;
        logic [1:0] cp;
        logic [1:0] id;
        logic [1:0] rw;
        logic [1:0] sz;
    } bbr_t;

    typedef struct packed {
        logic       cmfca;
        logic       cmfpa;
        logic       ebba;
        logic       umd;
        logic       rsv11;
        logic       pcba;
        logic [1:0] rsv9_8;
        logic       cmfcb;
        logic       cmfpb;
        logic       rsv5;
        logic       seq;
        logic       dbeb;
        logic       pcbb;
        logic [1:0] rsv1_0;
    } brcr_t;

    // 01 selects the first cycle kind, 10 the second, 11 either; 00 never matches
    function automatic logic field_hit(input logic [1:0] f, input logic second);
        return (f == 2'b11) || (f == 2'b01 && !second) || (f == 2'b10 && second);
    endfunction

    // Size field: 00 no size condition, 01 byte, 10 word, 11 long
    function automatic logic size_hit(input logic [1:0] f, input logic [1:0] sz);
        logic hit;
        case (f)
            2'b00:   hit = 1'b1;
            2'b01:   hit = (sz == 2'b00);
            2'b10:   hit = (sz == 2'b01);
            default: hit = (sz == 2'b10);
        endcase
        return hit;
    endfunction

    // Big-endian byte lanes: byte address 0 drives bits 31:24
    function automatic logic [31:0] lane_mask(input logic [1:0] sz, input logic [1:0] a);
        logic [31:0] m;
        case (sz)
            2'b00:   m = 32'hFF00_0000 >> {a, 3'b000};
            2'b01:   m = a[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            default: m = 32'hFFFF_FFFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sh7604_ubc_cmp.sv
// rtl/sh7604_ubc_cmp.sv - one break channel comparator (address, bus cycle, optional data)
module sh7604_ubc_cmp
    import sh7604_pkg::*;
#(
    parameter bit DATA_CMP = 1'b0
) (
    input  logic        MON_VALID,
    input  logic [31:0] MON_A,
    input  logic [31:0] MON_D,
    input  logic        MON_DMA,
    input  logic        MON_IF,
    input  logic        MON_WE,
    input  logic [1:0]  MON_SZ,
    input  logic [31:0] BAR,
    input  logic [31:0] BAMR,
    input  logic [15:0] BBR,
    input  logic [31:0] BDR,
    input  logic [31:0] BDMR,
    input  logic        DBE,
    output logic        MATCH
);

    bbr_t bbr;
    logic addr_ok;
    logic bus_ok;
    logic data_ok;
    logic unused_bbr;

    assign bbr        = BBR;
    assign unused_bbr = ^bbr.rsv;

    assign addr_ok = (((MON_A ^ BAR) & ~BAMR) == 32'h0);

    assign bus_ok = field_hit(bbr.cp, MON_DMA)
                  & field_hit(bbr.id, ~MON_IF)
                  & field_hit(bbr.rw, MON_WE)
                  & size_hit(bbr.sz, MON_SZ);

    // Data compare only qualifies data cycles; fetches pass on address alone
    assign data_ok = !(DATA_CMP && DBE && !MON_IF)
                   || (((MON_D ^ BDR) & ~BDMR & lane_mask(MON_SZ, MON_A[1:0])) == 32'h0);

    assign MATCH = MON_VALID & addr_ok & bus_ok & data_ok;

endmodule

// File: rtl/sh7604_ubc_brk.sv
// rtl/sh7604_ubc_brk.sv - SH7604 user break controller: two channels, sequential mode, level-15 request
module sh7604_ubc_brk
    import sh7604_pkg::*;
#(
    parameter int DISABLE = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CE_R,
    input  logic        EN,
    input  logic        RES_N,
    input  logic [31:0] BARA,
    input  logic [31:0] BAMRA,
    input  logic [31:0] BARB,
    input  logic [31:0] BAMRB,
    input  logic [31:0] BDRB,
    input  logic [31:0] BDMRB,
    input  logic [15:0] BBRA,
    input  logic [15:0] BBRB,
    input  logic [15:0] BRCR,
    input  logic        MON_VALID,
    input  logic [31:0] MON_A,
    input  logic [31:0] MON_D,
    input  logic        MON_DMA,
    input  logic        MON_IF,
    input  logic        MON_WE,
    input  logic [1:0]  MON_SZ,
    output logic        IRQ,
    input  logic        IRQ_ACK,
    output logic        CMFA_SET,
    output logic        CMFB_SET,
    output logic        FLAG_DMA
);

    localparam bit ACTIVE = (DISABLE == 0);

    brcr_t      brcr;
    logic       match_a;
    logic       match_b;
    ubc_state_e state_q;
    ubc_state_e state_d;
    logic       pulse_a_q;
    logic       pulse_b_q;
    logic       dma_q;
    logic       unused_brcr;

    assign brcr        = BRCR;
    assign unused_brcr = ^{BRCR[15:5], BRCR[2:0]};

    sh7604_ubc_cmp #(.DATA_CMP(1'b0)) u_cmp_a (
        .MON_VALID (MON_VALID),
        .MON_A     (MON_A),
        .MON_D     (MON_D),
        .MON_DMA   (MON_DMA),
        .MON_IF    (MON_IF),
        .MON_WE    (MON_WE),
        .MON_SZ    (MON_SZ),
        .BAR       (BARA),
        .BAMR      (BAMRA),
        .BBR       (BBRA),
        .BDR       (32'h0),
        .BDMR      (32'h0),
        .DBE       (1'b0),
        .MATCH     (match_a)
    );

    sh7604_ubc_cmp #(.DATA_CMP(1'b1)) u_cmp_b (
        .MON_VALID (MON_VALID),
        .MON_A     (MON_A),
        .MON_D     (MON_D),
        .MON_DMA   (MON_DMA),
        .MON_IF    (MON_IF),
        .MON_WE    (MON_WE),
        .MON_SZ    (MON_SZ),
        .BAR       (BARB),
        .BAMR      (BAMRB),
        .BBR       (BBRB),
        .BDR       (BDRB),
        .BDMR      (BDMRB),
        .DBE       (brcr.dbeb),
        .MATCH     (match_b)
    );

    // A and B on the same cycle in sequential mode only arms; B must come later
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (brcr.seq) begin
                    if (match_a) state_d = ST_SEQ_A;
                end else if (match_a || match_b) begin
                    state_d = ST_PEND;
                end
            end
            ST_SEQ_A: if (match_b) state_d = ST_PEND;
            ST_PEND:  if (IRQ_ACK) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            pulse_a_q <= 1'b0;
            pulse_b_q <= 1'b0;
            dma_q     <= 1'b0;
        end else if (CE_R) begin
            if (!RES_N) begin
                state_q   <= ST_IDLE;
                pulse_a_q <= 1'b0;
                pulse_b_q <= 1'b0;
                dma_q     <= 1'b0;
            end else if (EN) begin
                state_q   <= state_d;
                pulse_a_q <= match_a;
                pulse_b_q <= match_b;
                dma_q     <= MON_DMA & (match_a | match_b);
            end else begin
                pulse_a_q <= 1'b0;
                pulse_b_q <= 1'b0;
                dma_q     <= 1'b0;
            end
        end
    end

    assign IRQ      = ACTIVE && (state_q == ST_PEND);
    assign CMFA_SET = ACTIVE && CE_R && pulse_a_q;
    assign CMFB_SET = ACTIVE && CE_R && pulse_b_q;
    assign FLAG_DMA = ACTIVE && CE_R && dma_q;

endmodule
